// File: rtl/buffer_pkg.sv
// Shared output/weight buffer definitions: bank packing ratio, control FSM states
// and elaboration-time sizing helpers.
package buffer_pkg;

    localparam int unsigned BANKS_PER_WORD = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so a single-entry range still gets a 1-bit index
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    function automatic int unsigned groups_of(input int unsigned buffer_num);
        return buffer_num / BANKS_PER_WORD;
    endfunction

endpackage

// File: rtl/ob_ddr_writeback_if.sv
// Output-buffer read port plus DDR write-FIFO port as seen by the writeback engine.
interface ob_ddr_writeback_if
    import buffer_pkg::*;
#(
    parameter int unsigned ADDR_LEN   = 16,
    parameter int unsigned DATA_LEN   = 64,
    parameter int unsigned BUFFER_NUM = 32
) ();
    localparam int unsigned GROUPS = groups_of(BUFFER_NUM);

    logic [ADDR_LEN-1:0]                ob_addr;
    logic [GROUPS-1:0]                  ob_rd_en;
    logic [BUFFER_NUM*DATA_LEN-1:0]     ob_data;
    logic                               ddr_fifo_full;
    logic                               ddr_fifo_wr;
    logic [BANKS_PER_WORD*DATA_LEN-1:0] ddr_fifo_data;

    modport master (
        output ob_addr, ob_rd_en, ddr_fifo_wr, ddr_fifo_data,
        input  ob_data, ddr_fifo_full
    );

    modport slave (
        input  ob_addr, ob_rd_en, ddr_fifo_wr, ddr_fifo_data,
        output ob_data, ddr_fifo_full
    );
endinterface

// File: rtl/skid_fifo2.sv
// Generic two-entry FIFO; head is the oldest entry and stays stable until popped.
module skid_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic         pop_ok_c;
    logic         push_ok_c;

    assign pop_ok_c  = pop && (count != 2'd0);
    assign push_ok_c = push && ((count != 2'd2) || pop_ok_c);
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok_c) rd_ptr_q <= ~rd_ptr_q;
            count <= count + 2'(push_ok_c) - 2'(pop_ok_c);
        end
    end
endmodule

// File: rtl/ob_ddr_writeback.sv
// Streams an output tile from the banked OB into the DDR write FIFO, one 8-bank
// group per DDR word, group-major, and issues the matching DDR write descriptor.
module ob_ddr_writeback
    import buffer_pkg::*;
#(
    parameter int unsigned DDR_ADDR_LEN = 32,
    parameter int unsigned ADDR_LEN     = 16,
    parameter int unsigned DATA_LEN     = 64,
    parameter int unsigned SINGLE_LEN   = 24,
    parameter int unsigned BUFFER_NUM   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    conf,
    input  logic [SINGLE_LEN-1:0]   word_num,
    input  logic [ADDR_LEN-1:0]     ob_st_addr,
    input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
    output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]   ddr_len,
    output logic                    ddr_conf,
    output logic                    idle,
    output logic                    done,
    ob_ddr_writeback_if.master      bus
);
    localparam int unsigned GROUPS = groups_of(BUFFER_NUM);
    localparam int unsigned G_W    = clogb2(GROUPS);
    localparam int unsigned WORD_W = BANKS_PER_WORD * DATA_LEN;

    state_t                  state_q, state_d;
    logic [SINGLE_LEN-1:0]   word_num_q, word_num_d;
    logic [SINGLE_LEN-1:0]   a_cnt_q, a_cnt_d;
    logic [ADDR_LEN-1:0]     ob_st_addr_q, ob_st_addr_d;
    logic [G_W-1:0]          g_cnt_q, g_cnt_d;
    logic [G_W-1:0]          infl_g_q;
    logic                    infl_q;
    logic                    issued_all_q, issued_all_d;
    logic [DDR_ADDR_LEN-1:0] ddr_st_addr_d;
    logic [SINGLE_LEN-1:0]   ddr_len_d;
    logic                    ddr_conf_d, idle_d, done_d;

    logic [1:0]              occ;
    logic [WORD_W-1:0]       head;
    logic [WORD_W-1:0]       grp_data [GROUPS];
    logic                    pop_c, issue_c, last_c, drained_c, a_wrap_c;

    for (genvar g = 0; g < GROUPS; g++) begin : g_slice
        assign grp_data[g] = bus.ob_data[g*WORD_W +: WORD_W];
    end

    // A read lands in the skid two edges later; reserve a slot before issuing it
    assign pop_c     = (occ != 2'd0) && !bus.ddr_fifo_full;
    assign issue_c   = (state_q == RUN) && !issued_all_q &&
                       ((3'(occ) + 3'(infl_q) - 3'(pop_c)) < 3'd2);
    assign a_wrap_c  = (a_cnt_q == word_num_q - SINGLE_LEN'(1));
    assign last_c    = a_wrap_c && (g_cnt_q == G_W'(GROUPS - 1));
    assign drained_c = !infl_q && ((occ == 2'd0) || ((occ == 2'd1) && pop_c));

    assign bus.ob_rd_en      = issue_c ? (GROUPS'(1) << g_cnt_q) : '0;
    assign bus.ob_addr       = ob_st_addr_q + ADDR_LEN'(a_cnt_q);
    assign bus.ddr_fifo_wr   = pop_c;
    assign bus.ddr_fifo_data = head;

    skid_fifo2 #(.W(WORD_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_q),
        .push_data (grp_data[infl_g_q]),
        .pop       (pop_c),
        .head      (head),
        .count     (occ)
    );

    // Next-state, counters and descriptor
    always_comb begin
        state_d       = state_q;
        word_num_d    = word_num_q;
        ob_st_addr_d  = ob_st_addr_q;
        a_cnt_d       = a_cnt_q;
        g_cnt_d       = g_cnt_q;
        issued_all_d  = issued_all_q;
        ddr_st_addr_d = ddr_st_addr_out;
        ddr_len_d     = ddr_len;
        ddr_conf_d    = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (conf) begin
                    state_d       = RUN;
                    word_num_d    = word_num;
                    ob_st_addr_d  = ob_st_addr;
                    a_cnt_d       = '0;
                    g_cnt_d       = '0;
                    issued_all_d  = (word_num == '0);
                    ddr_st_addr_d = ddr_st_addr;
                    ddr_len_d     = word_num * SINGLE_LEN'(GROUPS * DATA_LEN);
                    ddr_conf_d    = 1'b1;
                end
            end
            RUN: begin
                if (issue_c) begin
                    if (a_wrap_c) begin
                        a_cnt_d = '0;
                        g_cnt_d = g_cnt_q + G_W'(1);
                    end else begin
                        a_cnt_d = a_cnt_q + SINGLE_LEN'(1);
                    end
                    if (last_c) begin
                        issued_all_d = 1'b1;
                        state_d      = DRAIN;
                    end
                end else if (issued_all_q) begin
                    // Empty tile: nothing to drain, finish straight away
                    if (drained_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            word_num_q      <= '0;
            ob_st_addr_q    <= '0;
            a_cnt_q         <= '0;
            g_cnt_q         <= '0;
            issued_all_q    <= 1'b0;
            infl_q          <= 1'b0;
            infl_g_q        <= '0;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
            ddr_conf        <= 1'b0;
            idle            <= 1'b1;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_num_q      <= word_num_d;
            ob_st_addr_q    <= ob_st_addr_d;
            a_cnt_q         <= a_cnt_d;
            g_cnt_q         <= g_cnt_d;
            issued_all_q    <= issued_all_d;
            infl_q          <= issue_c;
            infl_g_q        <= g_cnt_q;
            ddr_st_addr_out <= ddr_st_addr_d;
            ddr_len         <= ddr_len_d;
            ddr_conf        <= ddr_conf_d;
            idle            <= idle_d;
            done            <= done_d;
        end
    end
endmodule

// File: tb/tb_ob_ddr_writeback.sv
// Directed bench for ob_ddr_writeback: OB read model, DDR FIFO monitor, scoreboard.
module tb_ob_ddr_writeback;
    localparam int unsigned ADDR_LEN   = 16;
    localparam int unsigned DATA_LEN   = 64;
    localparam int unsigned BUFFER_NUM = 32;
    localparam int          GROUPS     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        conf;
    logic [23:0] word_num;
    logic [15:0] ob_st_addr;
    logic [31:0] ddr_st_addr;
    logic [31:0] ddr_st_addr_out;
    logic [23:0] ddr_len;
    logic        ddr_conf;
    logic        idle;
    logic        done;
    logic        full = 1'b0;
    bit          rand_full;
    bit          full_force;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int viol;
    int occ_m, infl_m;
    int          rd_g[$];
    logic [15:0] rd_a[$];
    int          rd_t[$];
    logic [511:0] wr_d[$];
    int          wr_t[$];
    int          done_t[$];
    logic        done_idle[$];
    int          dconf_t[$];

    always #5 clk = ~clk;

    ob_ddr_writeback_if #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .BUFFER_NUM(BUFFER_NUM)) bus ();

    assign bus.ddr_fifo_full = full;

    ob_ddr_writeback dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .conf            (conf),
        .word_num        (word_num),
        .ob_st_addr      (ob_st_addr),
        .ddr_st_addr     (ddr_st_addr),
        .ddr_st_addr_out (ddr_st_addr_out),
        .ddr_len         (ddr_len),
        .ddr_conf        (ddr_conf),
        .idle            (idle),
        .done            (done),
        .bus             (bus)
    );

    function automatic logic [63:0] bank_val(input int b, input logic [15:0] a);
        return {16'hCAFE, 8'(b), 8'h5A, a, ~a};
    endfunction

    function automatic logic [511:0] exp_word(input int g, input logic [15:0] a);
        logic [511:0] w;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = bank_val(g*8 + k, a);
        return w;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        else passed++;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        full = rand_full ? 1'($urandom_range(0, 1)) : full_force;
    end

    // OB model: one-cycle read latency, junk when not reading
    always @(posedge clk) begin : ob_model
        logic [2047:0] d;
        for (int b = 0; b < 32; b++) d[b*64 +: 64] = bank_val(b, bus.ob_addr);
        if (|bus.ob_rd_en) bus.ob_data <= d;
        else               bus.ob_data <= {64{32'hDEADBEEF}};
    end

    always @(negedge clk) begin : monitor
        int g;
        int rd, wr;
        if (!rst_n) begin
            occ_m  = 0;
            infl_m = 0;
        end else begin
            rd = int'(|bus.ob_rd_en);
            wr = int'(bus.ddr_fifo_wr);
            if (rd != 0) begin
                g = 0;
                for (int k = 0; k < GROUPS; k++) if (bus.ob_rd_en[k]) g = k;
                if (!$onehot(bus.ob_rd_en)) viol++;
                if (occ_m + infl_m - wr >= 2) viol++;
                rd_g.push_back(g);
                rd_a.push_back(bus.ob_addr);
                rd_t.push_back(cyc);
            end
            if (wr != 0) begin
                if (occ_m == 0) viol++;
                wr_d.push_back(bus.ddr_fifo_data);
                wr_t.push_back(cyc);
            end
            if (done) begin
                done_t.push_back(cyc);
                done_idle.push_back(idle);
            end
            if (ddr_conf) dconf_t.push_back(cyc);
            occ_m  = occ_m + infl_m - wr;
            infl_m = rd;
            if (occ_m > 2) viol++;
        end
    end

    task automatic clear_mon();
        rd_g.delete(); rd_a.delete(); rd_t.delete();
        wr_d.delete(); wr_t.delete();
        done_t.delete(); done_idle.delete(); dconf_t.delete();
        viol = 0;
    endtask

    task automatic do_conf(input logic [23:0] wn, input logic [15:0] oba,
                           input logic [31:0] ddra, output int t);
        @(posedge clk); #1;
        word_num = wn; ob_st_addr = oba; ddr_st_addr = ddra; conf = 1'b1; t = cyc;
        @(posedge clk); #1;
        conf = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_t.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_t.size() == 0) check({tag, " done timeout"}, 512'(0), 512'(1));
    endtask

    task automatic check_rst(input string p);
        check({p, " idle"},     512'(idle), 512'(1));
        check({p, " ddr_conf"}, 512'(ddr_conf), 512'(0));
        check({p, " done"},     512'(done), 512'(0));
        check({p, " rd_en"},    512'(bus.ob_rd_en), 512'(0));
        check({p, " wr"},       512'(bus.ddr_fifo_wr), 512'(0));
        check({p, " ob_addr"},  512'(bus.ob_addr), 512'(0));
        check({p, " ddr_len"},  512'(ddr_len), 512'(0));
        check({p, " st_addr"},  512'(ddr_st_addr_out), 512'(0));
        check({p, " data"},     bus.ddr_fifo_data, 512'(0));
    endtask

    task automatic verify_run(input string tag, input int t0, input int wn,
                              input logic [15:0] oba, input bit timed);
        int n = GROUPS * wn;
        check({tag, " reads"},  512'(rd_g.size()), 512'(n));
        check({tag, " writes"}, 512'(wr_d.size()), 512'(n));
        for (int i = 0; i < n; i++) begin
            int g;
            logic [15:0] a;
            g = i / wn;
            a = oba + 16'(i % wn);
            if (i < rd_g.size()) begin
                check($sformatf("%s rd%0d", tag, i), 512'({8'(rd_g[i]), rd_a[i]}), 512'({8'(g), a}));
                if (timed) check($sformatf("%s rd%0d t", tag, i), 512'(rd_t[i] - t0), 512'(1 + i));
            end
            if (i < wr_d.size()) begin
                check($sformatf("%s wr%0d", tag, i), wr_d[i], exp_word(g, a));
                if (timed) check($sformatf("%s wr%0d t", tag, i), 512'(wr_t[i] - t0), 512'(3 + i));
            end
        end
        check({tag, " done cnt"}, 512'(done_t.size()), 512'(1));
        if (done_t.size() > 0) begin
            if (timed) check({tag, " done t"}, 512'(done_t[0] - t0), 512'(3 + n));
            check({tag, " idle@done"}, 512'(done_idle[0]), 512'(1));
        end
        check({tag, " flow"}, 512'(viol), 512'(0));
        check({tag, " dconf cnt"}, 512'(dconf_t.size()), 512'(1));
        if (dconf_t.size() > 0) check({tag, " dconf t"}, 512'(dconf_t[0] - t0), 512'(1));
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; conf = 1'b0; word_num = '0; ob_st_addr = '0; ddr_st_addr = '0;
        rand_full = 1'b0; full_force = 1'b0; viol = 0; occ_m = 0; infl_m = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_rst("reset");

        // Basic tile, no backpressure
        clear_mon();
        do_conf(24'd3, 16'h0010, 32'h8000, t0);
        @(negedge clk);
        check("basic ddr_conf", 512'(ddr_conf), 512'(1));
        check("basic ddr_len",  512'(ddr_len), 512'(768));
        check("basic st_addr",  512'(ddr_st_addr_out), 512'(32'h8000));
        check("basic idle",     512'(idle), 512'(0));
        wait_done("basic", 100);
        verify_run("basic", t0, 3, 16'h0010, 1'b1);
        @(negedge clk);
        check("basic done pulse", 512'(done), 512'(0));
        check("basic len hold",   512'(ddr_len), 512'(768));

        // Random backpressure
        clear_mon();
        rand_full = 1'b1;
        do_conf(24'd3, 16'h0010, 32'h8000, t0);
        wait_done("bp", 600);
        rand_full = 1'b0;
        @(posedge clk);
        verify_run("bp", t0, 3, 16'h0010, 1'b0);

        // Empty tile
        clear_mon();
        do_conf(24'd0, 16'h0020, 32'hABCD0000, t0);
        @(negedge clk);
        check("zero ddr_conf", 512'(ddr_conf), 512'(1));
        check("zero ddr_len",  512'(ddr_len), 512'(0));
        check("zero st_addr",  512'(ddr_st_addr_out), 512'(32'hABCD0000));
        wait_done("zero", 20);
        check("zero done cnt", 512'(done_t.size()), 512'(1));
        if (done_t.size() > 0) check("zero done t", 512'(done_t[0] - t0), 512'(2));
        check("zero reads",  512'(rd_g.size()), 512'(0));
        check("zero writes", 512'(wr_d.size()), 512'(0));

        // conf while busy must be ignored
        clear_mon();
        do_conf(24'd3, 16'h0010, 32'h8000, t0);
        repeat (3) @(posedge clk);
        #1 word_num = 24'd5; ob_st_addr = 16'h0040; ddr_st_addr = 32'h1234; conf = 1'b1;
        @(posedge clk);
        #1 conf = 1'b0;
        wait_done("midconf", 100);
        verify_run("midconf", t0, 3, 16'h0010, 1'b1);
        check("midconf st_addr", 512'(ddr_st_addr_out), 512'(32'h8000));
        check("midconf ddr_len", 512'(ddr_len), 512'(768));

        // Reset mid-stream under backpressure
        clear_mon();
        do_conf(24'd3, 16'h0010, 32'h8000, t0);
        for (int n = 0; n < 50 && wr_d.size() < 5; n++) @(posedge clk);
        #1 full_force = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_rst("midrst");
        check("midrst writes", 512'(wr_d.size()), 512'(5));
        check("midrst no done", 512'(done_t.size()), 512'(0));
        full_force = 1'b0;
        @(posedge clk);
        clear_mon();
        do_conf(24'd3, 16'h0010, 32'h8000, t0);
        wait_done("postrst", 100);
        verify_run("postrst", t0, 3, 16'h0010, 1'b1);

        // OB address wrap
        clear_mon();
        do_conf(24'd3, 16'hFFFE, 32'h0100, t0);
        wait_done("wrap", 100);
        verify_run("wrap", t0, 3, 16'hFFFE, 1'b1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
